// File: rtl/instr_sequencer.sv
// Control-flow sequencer for the 4-bit core: A1..X3 cycle counter, OPR/OPA latching,
// two-word instruction tracking, PC increment/load, FIM pair writes and a JMS/BBL return stack.
// Optional macro STACK_GUARD_EN: saturating stack with sticky overflow/underflow flags.
module instr_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [3:0]        romNibble,
  input  logic [ADDR_W-1:0] pcCur,
  input  logic              carryIn,
  input  logic              accZero,
  input  logic              testIn,
  input  logic              regZeroNext,
  output logic [2:0]        cycle,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic              word2,
  output logic              pcInc,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcTarget,
  output logic              pairWe,
  output logic [3:0]        pairAddr,
  output logic [7:0]        pairDin,
  output logic              stackOvf,
  output logic              stackUnf
);

  // Handshake-free block: every action is a single-clock pulse tied to a fixed cycle slot,
  // so consumers sample pcInc/pcLoad/pairWe on the clock edge that ends the pulse.
  localparam logic [0:0] S_FETCH1 = 1'b0;
  localparam logic [0:0] S_WORD2  = 1'b1;

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_BBL = 4'hC;

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]        cycle_q, cycle_d;
  logic [0:0]        state_q, state_d;
  logic [3:0]        opr_q, opr_d, opa_q, opa_d;
  logic [3:0]        w2_hi_q, w2_hi_d, w2_lo_q, w2_lo_d;
  logic              cc_q, cc_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              wrap, two_word, cc_raw;
  logic              do_push, do_pop, push_en;
  logic [IW-1:0]     idx_push, idx_pop;
  logic [PW-1:0]     ptr_dec;
  logic [ADDR_W-1:0] pop_val, far_tgt, near_tgt;

  assign wrap     = (cycle_q == 3'd7);
  assign two_word = (opr_q == OP_JCN) || (opr_q == OP_JUN) || (opr_q == OP_JMS) ||
                    (opr_q == OP_ISZ) || ((opr_q == OP_FIM) && !opa_q[0]);
  assign cc_raw   = ((~testIn & opa_q[0]) | (carryIn & opa_q[1]) | (accZero & opa_q[2])) ^ opa_q[3];

  always_comb begin
    cycle_d = cycle_q + 3'd1;
    state_d = state_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    w2_hi_d = w2_hi_q;
    w2_lo_d = w2_lo_q;
    cc_d    = cc_q;
    if (wrap) state_d = (state_q == S_FETCH1 && two_word) ? S_WORD2 : S_FETCH1;
    // Word 1 nibbles become OPR/OPA; word 2 nibbles form the 8-bit operand.
    if (state_q == S_FETCH1) begin
      if (cycle_q == 3'd3) opr_d = romNibble;
      if (cycle_q == 3'd4) opa_d = romNibble;
      if (wrap)            cc_d  = cc_raw;
    end else begin
      if (cycle_q == 3'd3) w2_hi_d = romNibble;
      if (cycle_q == 3'd4) w2_lo_d = romNibble;
    end
  end

  always_comb begin
    far_tgt        = pcCur;
    far_tgt[11:0]  = {opa_q, w2_hi_q, w2_lo_q};
    near_tgt       = pcCur;
    near_tgt[7:0]  = {w2_hi_q, w2_lo_q};
    do_push  = 1'b0;
    do_pop   = 1'b0;
    pcLoad   = 1'b0;
    pcTarget = '0;
    pairWe   = 1'b0;
    pairAddr = 4'h0;
    pairDin  = 8'h00;
    if (wrap && state_q == S_WORD2) begin
      case (opr_q)
        OP_JUN: begin pcLoad = 1'b1; pcTarget = far_tgt; end
        OP_JMS: begin pcLoad = 1'b1; pcTarget = far_tgt; do_push = 1'b1; end
        OP_JCN: if (cc_q)         begin pcLoad = 1'b1; pcTarget = near_tgt; end
        OP_ISZ: if (!regZeroNext) begin pcLoad = 1'b1; pcTarget = near_tgt; end
        OP_FIM: begin
          pairWe   = 1'b1;
          pairAddr = {opa_q[3:1], 1'b0};
          pairDin  = {w2_hi_q, w2_lo_q};
        end
        default: ;
      endcase
    end else if (wrap && opr_q == OP_BBL) begin
      pcLoad   = 1'b1;
      pcTarget = pop_val;
      do_pop   = 1'b1;
    end
  end

`ifdef STACK_GUARD_EN
  // ptr counts valid entries; full pushes are dropped and empty pops return zero.
  localparam logic [PW-1:0] PTR_FULL = PW'(STACK_DEPTH);
  logic ovf_q, unf_q, pop_en;

  always_comb begin
    push_en  = do_push && (ptr_q != PTR_FULL);
    pop_en   = do_pop && (ptr_q != '0);
    ptr_dec  = ptr_q - 1'b1;
    idx_push = ptr_q[IW-1:0];
    idx_pop  = ptr_dec[IW-1:0];
    pop_val  = (ptr_q != '0) ? stack_q[idx_pop] : '0;
    ptr_d    = ptr_q;
    if (push_en)     ptr_d = ptr_q + 1'b1;
    else if (pop_en) ptr_d = ptr_dec;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push && !push_en) ovf_q <= 1'b1;
      if (do_pop && !pop_en)   unf_q <= 1'b1;
    end
  end

  assign stackOvf = ovf_q;
  assign stackUnf = unf_q;
`else
  // Circular pointer: a push past depth silently overwrites the oldest entry.
  localparam logic [PW-1:0] PTR_LAST = PW'(STACK_DEPTH - 1);

  always_comb begin
    push_en  = do_push;
    ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
    idx_push = ptr_q[IW-1:0];
    idx_pop  = ptr_dec[IW-1:0];
    pop_val  = stack_q[idx_pop];
    ptr_d    = ptr_q;
    if (do_push)     ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    else if (do_pop) ptr_d = ptr_dec;
  end

  assign stackOvf = 1'b0;
  assign stackUnf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle_q <= 3'd0;
      state_q <= S_FETCH1;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      w2_hi_q <= 4'h0;
      w2_lo_q <= 4'h0;
      cc_q    <= 1'b0;
      ptr_q   <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      cycle_q <= cycle_d;
      state_q <= state_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      w2_hi_q <= w2_hi_d;
      w2_lo_q <= w2_lo_d;
      cc_q    <= cc_d;
      ptr_q   <= ptr_d;
      if (push_en) stack_q[idx_push] <= pcCur;
    end
  end

  assign cycle = cycle_q;
  assign opr   = opr_q;
  assign opa   = opa_q;
  assign word2 = (state_q == S_WORD2);
  assign pcInc = (cycle_q == 3'd2);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instructions checked
// against an instruction-level model with a return-stack array and expected-target queue.
module tb_instr_sequencer;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              rstN;
  logic [3:0]        romNibble;
  logic [ADDR_W-1:0] pcCur;
  logic              carryIn, accZero, testIn, regZeroNext;
  logic [2:0]        cycle;
  logic [3:0]        opr, opa;
  logic              word2, pcInc, pcLoad;
  logic [ADDR_W-1:0] pcTarget;
  logic              pairWe;
  logic [3:0]        pairAddr;
  logic [7:0]        pairDin;
  logic              stackOvf, stackUnf;

  instr_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .romNibble(romNibble), .pcCur(pcCur),
    .carryIn(carryIn), .accZero(accZero), .testIn(testIn), .regZeroNext(regZeroNext),
    .cycle(cycle), .opr(opr), .opa(opa), .word2(word2), .pcInc(pcInc), .pcLoad(pcLoad),
    .pcTarget(pcTarget), .pairWe(pairWe), .pairAddr(pairAddr), .pairDin(pairDin),
    .stackOvf(stackOvf), .stackUnf(stackUnf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: return addresses, ring position / fill count, sticky flags.
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] m_mem [DEPTH];
  int                m_pos;
  bit                m_ovf, m_unf;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pos = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [ADDR_W-1:0] ret);
`ifdef STACK_GUARD_EN
    if (m_pos == DEPTH) m_ovf = 1;
    else begin m_mem[m_pos] = ret; m_pos = m_pos + 1; end
`else
    m_mem[m_pos] = ret;
    m_pos = (m_pos + 1) % DEPTH;
`endif
  endtask

  task automatic model_pop(output logic [ADDR_W-1:0] ret);
`ifdef STACK_GUARD_EN
    if (m_pos == 0) begin ret = '0; m_unf = 1; end
    else begin m_pos = m_pos - 1; ret = m_mem[m_pos]; end
`else
    m_pos = (m_pos + DEPTH - 1) % DEPTH;
    ret = m_mem[m_pos];
`endif
  endtask

  // Driver: one 8-clock instruction cycle starting mid cycle 0; samples the X3 outputs.
  task automatic run_ic(input logic [3:0] n3, input logic [3:0] n4, input logic exp_w2,
                        output logic ld, output logic [ADDR_W-1:0] tgt, output logic we,
                        output logic [3:0] pa, output logic [7:0] pd,
                        output logic [3:0] o_opr, output logic [3:0] o_opa);
    ld = 0; tgt = '0; we = 0; pa = '0; pd = '0; o_opr = '0; o_opa = '0;
    for (int c = 0; c < 8; c++) begin
      romNibble = (c == 3) ? n3 : (c == 4) ? n4 : 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (cycle !== 3'(c)) begin
        failures++; $display("FAIL cycle_count: got %0d exp %0d", cycle, c);
      end
      checks++;
      if (pcInc !== (c == 2)) begin
        failures++; $display("FAIL pc_inc at cycle %0d: got %b", c, pcInc);
      end
      checks++;
      if (word2 !== exp_w2) begin
        failures++; $display("FAIL word2 at cycle %0d: got %b exp %b", c, word2, exp_w2);
      end
      if (c != 7) begin
        checks++;
        if (pcLoad !== 1'b0 || pairWe !== 1'b0) begin
          failures++; $display("FAIL early_pulse at cycle %0d: pcLoad=%b pairWe=%b exp 0", c, pcLoad, pairWe);
        end
      end else begin
        ld = pcLoad; tgt = pcTarget; we = pairWe; pa = pairAddr; pd = pairDin;
        o_opr = opr; o_opa = opa;
      end
      @(negedge clk);
    end
  endtask

  // Runs one instruction and checks it against the model's expectations.
  task automatic exec_instr(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [ADDR_W-1:0] pc, input string name,
                            output logic obs_ld, output logic [ADDR_W-1:0] obs_tgt);
    logic [3:0] op, oa, o_opr, o_opa, pa, e_pa;
    logic [7:0] pd, e_pd;
    logic       ld1, we1, ld, we, two, cc, e_ld, e_we;
    logic [ADDR_W-1:0] tgt1, tgt, e_tgt, far_t, near_t, popped;
    op = b1[7:4];
    oa = b1[3:0];
    pcCur = pc;
    two = (op == 4'h1) || (op == 4'h4) || (op == 4'h5) || (op == 4'h7) || (op == 4'h2 && !oa[0]);
    cc  = (!testIn && oa[0]) || (carryIn && oa[1]) || (accZero && oa[2]);
    if (oa[3]) cc = !cc;
    far_t  = ADDR_W'(((int'(pc) >> 12) << 12) + int'({oa, b2}));
    near_t = ADDR_W'(((int'(pc) >> 8) << 8) + int'(b2));
    e_ld = 0; e_tgt = '0; e_we = 0; e_pa = '0; e_pd = '0;
    if (two) begin
      case (op)
        4'h4: begin e_ld = 1; e_tgt = far_t; end
        4'h5: begin e_ld = 1; e_tgt = far_t; model_push(pc); end
        4'h1: begin e_ld = cc; e_tgt = near_t; end
        4'h7: begin e_ld = !regZeroNext; e_tgt = near_t; end
        default: begin e_we = 1; e_pa = oa & 4'hE; e_pd = b2; end
      endcase
    end else if (op == 4'hC) begin
      model_pop(popped);
      e_ld = 1; e_tgt = popped;
    end
    if (e_ld) exp_q.push_back(e_tgt);

    run_ic(b1[7:4], b1[3:0], 1'b0, ld1, tgt1, we1, pa, pd, o_opr, o_opa);
    checks++;
    if (o_opr !== op || o_opa !== oa) begin
      failures++; $display("FAIL %s opr_opa: got %h%h exp %h", name, o_opr, o_opa, b1);
    end
    ld = ld1; tgt = tgt1; we = we1;
    if (two) begin
      checks++;
      if (ld1 !== 1'b0 || we1 !== 1'b0) begin
        failures++; $display("FAIL %s word1_action: pcLoad=%b pairWe=%b exp 0", name, ld1, we1);
      end
      run_ic(b2[7:4], b2[3:0], 1'b1, ld, tgt, we, pa, pd, o_opr, o_opa);
      checks++;
      if (o_opr !== op || o_opa !== oa) begin
        failures++; $display("FAIL %s opr_opa_held: got %h%h exp %h", name, o_opr, o_opa, b1);
      end
    end
    checks++;
    if (ld !== e_ld) begin
      failures++; $display("FAIL %s pcLoad: got %b exp %b", name, ld, e_ld);
    end
    if (ld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL %s pcTarget: got %h exp no load", name, tgt);
      end else begin
        e_tgt = exp_q.pop_front();
        if (tgt !== e_tgt) begin
          failures++; $display("FAIL %s pcTarget: got %h exp %h", name, tgt, e_tgt);
        end
      end
    end
    checks++;
    if (we !== e_we) begin
      failures++; $display("FAIL %s pairWe: got %b exp %b", name, we, e_we);
    end
    if (e_we) begin
      checks++;
      if (pa !== e_pa || pd !== e_pd) begin
        failures++; $display("FAIL %s pair: got addr %h din %h exp addr %h din %h", name, pa, pd, e_pa, e_pd);
      end
    end
    checks++;
    if (stackOvf !== m_ovf || stackUnf !== m_unf) begin
      failures++; $display("FAIL %s flags: got ovf %b unf %b exp ovf %b unf %b", name, stackOvf, stackUnf, m_ovf, m_unf);
    end
    obs_ld = ld;
    obs_tgt = tgt;
  endtask

  task automatic test_reset();
    rstN = 1'b0; romNibble = '0; pcCur = '0;
    carryIn = 0; accZero = 0; testIn = 0; regZeroNext = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cycle !== 3'd0 || word2 !== 1'b0 || opr !== 4'h0 || opa !== 4'h0) begin
      failures++; $display("FAIL reset_state: cycle %0d word2 %b opr %h opa %h exp 0", cycle, word2, opr, opa);
    end
    checks++;
    if (pcInc !== 1'b0 || pcLoad !== 1'b0 || pcTarget !== '0 || pairWe !== 1'b0) begin
      failures++; $display("FAIL reset_pc: inc %b load %b tgt %h we %b exp 0", pcInc, pcLoad, pcTarget, pairWe);
    end
    checks++;
    if (pairAddr !== 4'h0 || pairDin !== 8'h00 || stackOvf !== 1'b0 || stackUnf !== 1'b0) begin
      failures++; $display("FAIL reset_misc: addr %h din %h ovf %b unf %b exp 0", pairAddr, pairDin, stackOvf, stackUnf);
    end
    @(negedge clk);
    rstN = 1'b1;
    model_reset();
  endtask

  task automatic test_jun();
    logic ld; logic [ADDR_W-1:0] tgt;
    exec_instr(8'h4A, 8'h5C, 12'h102, "jun", ld, tgt);
    checks++;
    if (ld !== 1'b1 || tgt !== 12'hA5C) begin
      failures++; $display("FAIL jun_direct: got load %b tgt %h exp 1 a5c", ld, tgt);
    end
  endtask

  task automatic test_jcn();
    logic ld; logic [ADDR_W-1:0] tgt;
    carryIn = 1;
    exec_instr(8'h12, 8'h80, 12'h312, "jcn_c1", ld, tgt);
    checks++;
    if (ld !== 1'b1 || tgt !== 12'h380) begin
      failures++; $display("FAIL jcn_taken: got load %b tgt %h exp 1 380", ld, tgt);
    end
    carryIn = 0;
    exec_instr(8'h12, 8'h80, 12'h312, "jcn_c0", ld, tgt);
    checks++;
    if (ld !== 1'b0) begin
      failures++; $display("FAIL jcn_not_taken: got load %b exp 0", ld);
    end
    exec_instr(8'h1A, 8'h80, 12'h312, "jcn_inv", ld, tgt);
    checks++;
    if (ld !== 1'b1 || tgt !== 12'h380) begin
      failures++; $display("FAIL jcn_inverted: got load %b tgt %h exp 1 380", ld, tgt);
    end
  endtask

  task automatic test_jms_bbl();
    logic ld; logic [ADDR_W-1:0] tgt;
    exec_instr(8'h51, 8'h23, 12'h045, "jms", ld, tgt);
    checks++;
    if (ld !== 1'b1 || tgt !== 12'h123) begin
      failures++; $display("FAIL jms_target: got load %b tgt %h exp 1 123", ld, tgt);
    end
    exec_instr(8'hC7, 8'h00, 12'h124, "bbl", ld, tgt);
    checks++;
    if (ld !== 1'b1 || tgt !== 12'h045) begin
      failures++; $display("FAIL bbl_return: got load %b tgt %h exp 1 045", ld, tgt);
    end
  endtask

  task automatic test_fim();
    logic ld; logic [ADDR_W-1:0] tgt;
    exec_instr(8'h24, 8'hAB, 12'h200, "fim", ld, tgt);
    exec_instr(8'h25, 8'hAB, 12'h200, "src", ld, tgt);
  endtask

  task automatic test_nested();
    logic ld; logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] ret [4];
    logic [ADDR_W-1:0] want [4];
    ret = '{12'h101, 12'h202, 12'h303, 12'h404};
`ifdef STACK_GUARD_EN
    want = '{12'h303, 12'h202, 12'h101, 12'h000};
`else
    want = '{12'h404, 12'h303, 12'h202, 12'h404};
`endif
    for (int i = 0; i < 4; i++)
      exec_instr(8'h58, 8'(8'h10 * i), ret[i], "nest_jms", ld, tgt);
    for (int i = 0; i < 4; i++) begin
      exec_instr(8'hC0, 8'h00, 12'h7F0, "nest_bbl", ld, tgt);
      checks++;
      if (tgt !== want[i]) begin
        failures++; $display("FAIL nest_pop%0d: got %h exp %h", i, tgt, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ld, we; logic [ADDR_W-1:0] tgt; logic [3:0] pa, o1, o2; logic [7:0] pd;
    pcCur = 12'h102;
    run_ic(4'h4, 4'hA, 1'b0, ld, tgt, we, pa, pd, o1, o2);
    for (int c = 0; c < 6; c++) begin
      romNibble = (c == 3) ? 4'h5 : 4'hC;
      #1;
      checks++;
      if (cycle !== 3'(c) || word2 !== 1'b1) begin
        failures++; $display("FAIL rmid_word2: cycle %0d word2 %b exp %0d 1", cycle, word2, c);
      end
      if (c < 5) @(negedge clk);
    end
    rstN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (pcLoad !== 1'b0 || cycle !== 3'd0 || word2 !== 1'b0) begin
        failures++; $display("FAIL rmid_hold: load %b cycle %0d word2 %b exp 0", pcLoad, cycle, word2);
      end
      @(negedge clk);
    end
    rstN = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cycle !== 3'd0 || word2 !== 1'b0 || stackOvf !== 1'b0 || stackUnf !== 1'b0) begin
      failures++; $display("FAIL rmid_release: cycle %0d word2 %b ovf %b unf %b exp 0", cycle, word2, stackOvf, stackUnf);
    end
    exec_instr(8'hC0, 8'h00, 12'h010, "rmid_bbl", ld, tgt);
    checks++;
    if (tgt !== 12'h000) begin
      failures++; $display("FAIL rmid_stack_empty: got %h exp 000", tgt);
    end
  endtask

  task automatic test_random();
    logic ld; logic [ADDR_W-1:0] tgt;
    logic [3:0] ops [7];
    logic [3:0] op;
    ops = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'hC, 4'h0};
    for (int i = 0; i < 48; i++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 4'h0) op = 4'($urandom_range(0, 15));
      carryIn     = 1'($urandom_range(0, 1));
      accZero     = 1'($urandom_range(0, 1));
      testIn      = 1'($urandom_range(0, 1));
      regZeroNext = 1'($urandom_range(0, 1));
      exec_instr({op, 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 255)),
                 ADDR_W'($urandom), "random", ld, tgt);
    end
  endtask

  initial begin
    test_reset();
    test_jun();
    test_jcn();
    test_jms_bbl();
    test_fim();
    test_nested();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
